// File: rtl/synth_voice_core.sv
// Polyphonic oscillator core: one shared phase-accumulator datapath walks every voice once
// per audio sample, mixes them into a saturated signed sample and offers it on valid/ready.
module synth_voice_core #(
  parameter int CLK_HZ     = 12_288_000,
  parameter int SAMPLE_HZ  = 48_000,
  parameter int NUM_VOICES = 4,
  parameter int SAMPLE_W   = 16,
  parameter int PHASE_W    = 24
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_VOICES-1:0]   voice_en,
  input  logic [4*NUM_VOICES-1:0] voice_tone,
  input  logic [2*NUM_VOICES-1:0] voice_wave,
  output logic [SAMPLE_W-1:0]     sample_out,
  output logic                    sample_valid,
  input  logic                    sample_ready,
  output logic                    clip,
  output logic                    overrun
);

  localparam int DIV     = CLK_HZ / SAMPLE_HZ;
  localparam int CNT_W   = $clog2(DIV);
  localparam int VOICE_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int ACC_W   = SAMPLE_W + $clog2(NUM_VOICES) + 1;
  localparam logic signed [SAMPLE_W:0] MAX_W = (SAMPLE_W+1)'((1 << (SAMPLE_W-1)) - 1);
  localparam logic signed [SAMPLE_W:0] MIN_W = ~MAX_W;

  // Equal-tempered increment relative to A4, evaluated at elaboration only.
  function automatic logic [PHASE_W-1:0] tone_inc(input int n);
    real r;
    r = 440.0;
    for (int i = 0; i < n; i++) r = r * 1.0594630943592953;
    for (int i = 0; i < PHASE_W; i++) r = r * 2.0;
    r = r / real'(SAMPLE_HZ);
    return PHASE_W'($rtoi(r + 0.5));
  endfunction

  logic [PHASE_W-1:0] inc_table [16];
  for (genvar gi = 0; gi < 16; gi++) begin : g_inc
    localparam logic [PHASE_W-1:0] INC = tone_inc(gi);
    assign inc_table[gi] = INC;
  end

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [VOICE_W-1:0]        voice_q, voice_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [PHASE_W-1:0]        phase_q [NUM_VOICES];
  logic [PHASE_W-1:0]        phase_d [NUM_VOICES];
  logic [SAMPLE_W-1:0]       sample_q, sample_d;
  logic                      valid_q, valid_d;
  logic                      clip_q, clip_d;
  logic                      overrun_q, overrun_d;

  logic                      tick;
  logic                      cur_en;
  logic [3:0]                cur_tone;
  logic [1:0]                cur_wave;
  logic [PHASE_W-1:0]        new_phase;
  logic [SAMPLE_W-1:0]       p;
  logic signed [SAMPLE_W:0]  two_h;
  logic signed [SAMPLE_W:0]  wave_val;

  assign tick = (cnt_q == CNT_W'(DIV - 1));

  // Voice currently in the datapath; its controls are sampled only in this cycle.
  always_comb begin
    cur_en    = voice_en[voice_q];
    cur_tone  = voice_tone[4*voice_q +: 4];
    cur_wave  = voice_wave[2*voice_q +: 2];
    new_phase = cur_en ? phase_q[voice_q] + inc_table[cur_tone] : '0;
    p         = new_phase[PHASE_W-1 -: SAMPLE_W];
    two_h     = $signed({1'b0, p[SAMPLE_W-2:0], 1'b0});
    case (cur_wave)
      2'b00:   wave_val = p[SAMPLE_W-1] ? -MAX_W : MAX_W;
      2'b01:   wave_val = $signed({~p[SAMPLE_W-1], ~p[SAMPLE_W-1], p[SAMPLE_W-2:0]});
      2'b10:   wave_val = p[SAMPLE_W-1] ? MAX_W - two_h : MIN_W + two_h;
      default: wave_val = '0;
    endcase
    if (!cur_en) wave_val = '0;
  end

  always_comb begin
    cnt_d     = tick ? '0 : cnt_q + CNT_W'(1);
    state_d   = state_q;
    voice_d   = voice_q;
    acc_d     = acc_q;
    phase_d   = phase_q;
    sample_d  = sample_q;
    valid_d   = valid_q;
    clip_d    = clip_q;
    overrun_d = overrun_q;

    if (valid_q && sample_ready) valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = ACCUM;
          voice_d = '0;
          acc_d   = '0;
        end
      end
      ACCUM: begin
        phase_d[voice_q] = new_phase;
        acc_d = acc_q + ACC_W'(wave_val);
        if (voice_q == VOICE_W'(NUM_VOICES - 1)) state_d = DONE;
        else voice_d = voice_q + VOICE_W'(1);
      end
      DONE: begin
        state_d = IDLE;
        if (acc_q > ACC_W'(MAX_W)) begin
          sample_d = SAMPLE_W'(MAX_W);
          clip_d   = 1'b1;
        end else if (acc_q < ACC_W'(MIN_W)) begin
          sample_d = SAMPLE_W'(MIN_W);
          clip_d   = 1'b1;
        end else begin
          sample_d = SAMPLE_W'(acc_q);
          clip_d   = 1'b0;
        end
        // A consumer accepting in this same cycle takes the old sample; no loss.
        valid_d = 1'b1;
        if (valid_q && !sample_ready) overrun_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      voice_q   <= '0;
      acc_q     <= '0;
      for (int i = 0; i < NUM_VOICES; i++) phase_q[i] <= '0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      clip_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      voice_q   <= voice_d;
      acc_q     <= acc_d;
      phase_q   <= phase_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      clip_q    <= clip_d;
      overrun_q <= overrun_d;
    end
  end

  assign sample_out   = sample_q;
  assign sample_valid = valid_q;
  assign clip         = clip_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_synth_voice_core.sv
// Directed bench for synth_voice_core at default parameters (DIV=256, 4 voices, 16-bit out).
module tb_synth_voice_core;

  localparam int DIV = 256;
  localparam int NV  = 4;

  logic               clk;
  logic               reset;
  logic [3:0]         voice_en;
  logic [15:0]        voice_tone;
  logic [7:0]         voice_wave;
  logic signed [15:0] sample_out;
  logic               sample_valid;
  logic               sample_ready;
  logic               clip;
  logic               overrun;

  int n_tests = 0;
  int n_fail  = 0;

  synth_voice_core dut (
    .clk          (clk),
    .reset        (reset),
    .voice_en     (voice_en),
    .voice_tone   (voice_tone),
    .voice_wave   (voice_wave),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .clip         (clip),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset(input logic [3:0] en, input logic [15:0] tone,
                             input logic [7:0] wave, input logic rdy);
    reset        = 1'b1;
    voice_en     = en;
    voice_tone   = tone;
    voice_wave   = wave;
    sample_ready = rdy;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Waits (bounded) for the next cycle with sample_valid high; a timeout counts as a failure.
  task automatic get_sample(output logic signed [15:0] s, output logic c, output bit ok);
    ok = 1'b0;
    s  = '0;
    c  = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (sample_valid === 1'b1) begin
        s  = sample_out;
        c  = clip;
        ok = 1'b1;
        break;
      end
    end
    if (ok) $display("[TB] sample %0d clip=%0b overrun=%0b t=%0t", s, c, overrun, $time);
    else begin
      n_tests++;
      n_fail++;
      $display("FAIL sample_timeout: no sample_valid within 400 cycles at t=%0t", $time);
    end
  endtask

  task automatic test_reset_idle();
    int lat;
    reset        = 1'b1;
    voice_en     = 4'b0000;
    voice_tone   = 16'h0000;
    voice_wave   = 8'h00;
    sample_ready = 1'b1;
    @(negedge clk);
    n_tests++; if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", sample_valid); end
    n_tests++; if (sample_out !== 16'sd0) begin n_fail++; $display("FAIL reset_out got %0d want 0", sample_out); end
    n_tests++; if (clip !== 1'b0) begin n_fail++; $display("FAIL reset_clip got %b want 0", clip); end
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %b want 0", overrun); end
    @(negedge clk);
    reset = 1'b0;
    lat = -1;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (sample_valid === 1'b1) begin lat = k; break; end
    end
    $display("[TB] idle first valid at cycle %0d out=%0d clip=%0b", lat, sample_out, clip);
    n_tests++; if (lat != DIV - 1 + NV + 2) begin n_fail++; $display("FAIL idle_latency got %0d want %0d", lat, DIV - 1 + NV + 2); end
    n_tests++; if (sample_out !== 16'sd0) begin n_fail++; $display("FAIL idle_out got %0d want 0", sample_out); end
    n_tests++; if (clip !== 1'b0) begin n_fail++; $display("FAIL idle_clip got %b want 0", clip); end
  endtask

  task automatic test_square();
    logic signed [15:0] s, e;
    logic c;
    bit ok;
    apply_reset(4'b0001, 16'h0000, 8'hFC, 1'b1);
    for (int k = 1; k <= 55; k++) begin
      get_sample(s, c, ok);
      if (!ok) break;
      e = (k < 55) ? 16'sd32767 : -16'sd32767;
      n_tests++;
      if (s !== e || c !== 1'b0) begin
        n_fail++;
        $display("FAIL square k=%0d got %0d clip=%b want %0d clip=0", k, s, c, e);
      end
    end
  endtask

  task automatic test_saturation();
    logic signed [15:0] s;
    logic c;
    bit ok;
    apply_reset(4'b1111, 16'h0000, 8'h00, 1'b1);
    for (int k = 1; k <= 55; k++) begin
      get_sample(s, c, ok);
      if (!ok) break;
      if (k == 1 || k == 2 || k == 54) begin
        n_tests++;
        if (s !== 16'sd32767 || c !== 1'b1) begin
          n_fail++;
          $display("FAIL sat_pos k=%0d got %0d clip=%b want 32767 clip=1", k, s, c);
        end
      end else if (k == 55) begin
        n_tests++;
        if (s !== -16'sd32768 || c !== 1'b1) begin
          n_fail++;
          $display("FAIL sat_neg k=%0d got %0d clip=%b want -32768 clip=1", k, s, c);
        end
      end
    end
    apply_reset(4'b0001, 16'h0000, 8'h00, 1'b1);
    get_sample(s, c, ok);
    if (ok) begin
      n_tests++;
      if (s !== 16'sd32767 || c !== 1'b0) begin
        n_fail++;
        $display("FAIL sat_single got %0d clip=%b want 32767 clip=0", s, c);
      end
    end
  endtask

  task automatic test_handshake();
    logic signed [15:0] s;
    logic c;
    bit ok;
    // Voice 0 saw, tone 0: successive samples -32168, -31567, -30966.
    apply_reset(4'b0001, 16'h0000, 8'hFD, 1'b0);
    get_sample(s, c, ok);
    if (ok) begin
      n_tests++; if (s !== -16'sd32168 || overrun !== 1'b0) begin n_fail++; $display("FAIL hold_first got %0d ovr=%b want -32168 ovr=0", s, overrun); end
      repeat (DIV) @(negedge clk);
      $display("[TB] hold second out=%0d valid=%b overrun=%b", sample_out, sample_valid, overrun);
      n_tests++; if (overrun !== 1'b1 || sample_out !== -16'sd31567 || sample_valid !== 1'b1) begin
        n_fail++; $display("FAIL hold_second got out=%0d v=%b ovr=%b want -31567 v=1 ovr=1", sample_out, sample_valid, overrun); end
      repeat (DIV) @(negedge clk);
      $display("[TB] hold third out=%0d valid=%b", sample_out, sample_valid);
      n_tests++; if (sample_out !== -16'sd30966 || sample_valid !== 1'b1) begin
        n_fail++; $display("FAIL hold_third got out=%0d v=%b want -30966 v=1", sample_out, sample_valid); end
      sample_ready = 1'b1;
      @(negedge clk);
      sample_ready = 1'b0;
      $display("[TB] ready pulse valid=%b overrun=%b", sample_valid, overrun);
      n_tests++; if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL pulse_valid got %b want 0", sample_valid); end
      n_tests++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_sticky got %b want 1", overrun); end
    end

    // Ready raised only inside the DONE cycle of the second frame.
    apply_reset(4'b0001, 16'h0000, 8'hFD, 1'b0);
    get_sample(s, c, ok);
    if (ok) begin
      repeat (DIV - 2) @(negedge clk);
      @(posedge clk);
      #1 sample_ready = 1'b1;
      @(posedge clk);
      #1 sample_ready = 1'b0;
      @(negedge clk);
      $display("[TB] ready-in-done out=%0d valid=%b overrun=%b", sample_out, sample_valid, overrun);
      n_tests++; if (sample_valid !== 1'b1 || overrun !== 1'b0 || sample_out !== -16'sd31567) begin
        n_fail++; $display("FAIL ready_in_done got v=%b ovr=%b out=%0d want v=1 ovr=0 out=-31567", sample_valid, overrun, sample_out); end
    end
  endtask

  task automatic test_disable();
    logic signed [15:0] s, e;
    logic c;
    bit ok;
    apply_reset(4'b0001, 16'h000C, 8'hFD, 1'b1);
    for (int k = 1; k <= 10; k++) begin
      get_sample(s, c, ok);
      if (!ok) return;
      e = 16'((((k * 307582) % 16777216) >> 8) - 32768);
      n_tests++;
      if (s !== e) begin n_fail++; $display("FAIL saw12 k=%0d got %0d want %0d", k, s, e); end
    end
    voice_en = 4'b0000;
    get_sample(s, c, ok);
    if (!ok) return;
    n_tests++; if (s !== 16'sd0) begin n_fail++; $display("FAIL disabled_out got %0d want 0", s); end
    voice_en = 4'b0001;
    get_sample(s, c, ok);
    if (!ok) return;
    n_tests++; if (s !== -16'sd31567) begin n_fail++; $display("FAIL reenable_out got %0d want -31567", s); end
  endtask

  task automatic test_triangle();
    logic signed [15:0] s, e;
    logic c;
    bit ok;
    int ph, pv, hv, ev, prev, d;
    ph = 0;
    prev = 0;
    apply_reset(4'b0001, 16'h000F, 8'hFE, 1'b1);
    for (int k = 1; k <= 60; k++) begin
      get_sample(s, c, ok);
      if (!ok) break;
      ph = (ph + 365779) % 16777216;
      pv = ph >> 8;
      hv = pv & 32767;
      ev = (pv >= 32768) ? (32767 - 2 * hv) : (-32768 + 2 * hv);
      e  = 16'(ev);
      n_tests++;
      if (s !== e) begin n_fail++; $display("FAIL tri k=%0d got %0d want %0d", k, s, e); end
      if (k > 1) begin
        d = int'(s) - prev;
        if (d < 0) d = -d;
        n_tests++;
        if (d > 2860) begin n_fail++; $display("FAIL tri_step k=%0d got step %0d want <= 2860", k, d); end
      end
      prev = int'(s);
    end
  endtask

  task automatic test_async_reset();
    logic signed [15:0] s;
    logic c;
    bit ok;
    apply_reset(4'b1111, 16'h0000, 8'h00, 1'b0);
    get_sample(s, c, ok);
    if (!ok) return;
    repeat (DIV) @(negedge clk);
    n_tests++; if (overrun !== 1'b1 || clip !== 1'b1 || sample_valid !== 1'b1 || sample_out !== 16'sd32767) begin
      n_fail++; $display("FAIL pre_reset got out=%0d v=%b clip=%b ovr=%b want 32767 1 1 1", sample_out, sample_valid, clip, overrun); end
    #2 reset = 1'b1;
    #1;
    $display("[TB] async reset out=%0d valid=%b clip=%b overrun=%b", sample_out, sample_valid, clip, overrun);
    n_tests++; if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL async_valid got %b want 0", sample_valid); end
    n_tests++; if (sample_out !== 16'sd0) begin n_fail++; $display("FAIL async_out got %0d want 0", sample_out); end
    n_tests++; if (clip !== 1'b0) begin n_fail++; $display("FAIL async_clip got %b want 0", clip); end
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL async_overrun got %b want 0", overrun); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    voice_en     = '0;
    voice_tone   = '0;
    voice_wave   = '0;
    sample_ready = 1'b0;
    test_reset_idle();
    test_square();
    test_saturation();
    test_handshake();
    test_disable();
    test_triangle();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
